interp_upsampler: RTL



---
 rtl/interp_pkg.sv | 10 +
 rtl/interp_fifo.sv | 57 +++++
 rtl/interp_upsampler.sv | 129 ++++++++++++
 3 files changed

// File: rtl/interp_pkg.sv
// Shared types and helpers for the interpolating upsampler.
package interp_pkg;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} interp_state_t;

    function automatic int RATIO(input int shift);
        return 1 << shift;
    endfunction

endpackage

// File: rtl/interp_fifo.sv
// Small synchronous FIFO feeding the upsampler; RESET flushes all entries.
module interp_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; pointers and count define what is valid.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/interp_upsampler.sv
// Linear-interpolating upsampler: one ramp step per CE, 2**SHIFT steps per input sample.
module interp_upsampler
    import interp_pkg::*;
#(
    parameter int MSB   = 15,
    parameter int SHIFT = 6,
    parameter int DEPTH = 2
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         CE,
    input  logic         ENABLE,
    input  logic [MSB:0] IDATA,
    input  logic         IVALID,
    output logic         IREADY,
    output logic [MSB:0] ODATA,
    output logic         UNDERRUN
);

    localparam int ACC_W = MSB + SHIFT + 1;
    localparam int RATIO_N = RATIO(SHIFT);
    localparam logic [SHIFT-1:0] LAST_PHASE = SHIFT'(RATIO_N - 1);

    interp_state_t            state, state_nxt;
    logic [ACC_W-1:0]         acc, acc_nxt;
    logic signed [MSB+1:0]    delta, delta_nxt;
    logic [MSB:0]             target, target_nxt;
    logic [SHIFT-1:0]         phase, phase_nxt;
    logic                     underrun_nxt;

    logic [MSB:0]             fifo_rdata;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic [MSB:0]             base;
    logic                     load;

    function automatic logic signed [MSB+1:0] seg_delta(input logic [MSB:0] s,
                                                        input logic [MSB:0] b);
        return $signed({1'b0, s}) - $signed({1'b0, b});
    endfunction

    function automatic logic [ACC_W-1:0] ramp_step(input logic [ACC_W-1:0] a,
                                                   input logic signed [MSB+1:0] d);
        logic signed [ACC_W-1:0] d_ext;
        d_ext = ACC_W'(d);
        return a + $unsigned(d_ext);
    endfunction

    assign IREADY    = !RESET && !fifo_full;
    assign fifo_push = IVALID && IREADY;
    assign ODATA     = ENABLE ? acc[MSB+SHIFT:SHIFT] : target;

    interp_fifo #(
        .WIDTH (MSB + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (fifo_push),
        .wdata (IDATA),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_nxt    = state;
        acc_nxt      = acc;
        delta_nxt    = delta;
        target_nxt   = target;
        phase_nxt    = phase;
        underrun_nxt = 1'b0;
        fifo_pop     = 1'b0;
        load         = 1'b0;
        // At a segment boundary acc equals target<<SHIFT, so target is the next base.
        base         = (state == RUN) ? target : acc[MSB+SHIFT:SHIFT];

        unique case (state)
            RUN: begin
                if (CE) begin
                    acc_nxt   = ramp_step(acc, delta);
                    phase_nxt = phase + 1'b1;
                    if (phase == LAST_PHASE) begin
                        if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_nxt    = HOLD;
                            underrun_nxt = 1'b1;
                        end
                    end
                end
            end
            default: begin
                if (!fifo_empty) load = 1'b1;
            end
        endcase

        if (load) begin
            fifo_pop   = 1'b1;
            target_nxt = fifo_rdata;
            delta_nxt  = seg_delta(fifo_rdata, base);
            acc_nxt    = {base, {SHIFT{1'b0}}};
            phase_nxt  = '0;
            state_nxt  = RUN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            acc      <= '0;
            delta    <= '0;
            target   <= '0;
            phase    <= '0;
            UNDERRUN <= 1'b0;
        end else begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            delta    <= delta_nxt;
            target   <= target_nxt;
            phase    <= phase_nxt;
            UNDERRUN <= underrun_nxt;
        end
    end

endmodule
